// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the
// execute stage. mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES
// busy cycles. mthi/mtlo write in one cycle, and mfhi/mflo read combinationally.
// Optional feature macro: MD_UNIT_DIV_EN. When it is undefined, the divider is
// absent and div/divu starts are ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] mdResult,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_op;
    logic [31:0]     r_a, r_b;
    logic [31:0]     r_hi, r_lo;

    logic            w_is_mul, w_is_div, w_accept, w_last;
    logic [63:0]     w_prod_s, w_prod_u;
    logic [31:0]     w_res_hi, w_res_lo;
    logic            w_res_we;

    assign w_is_mul = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
`ifdef MD_UNIT_DIV_EN
    assign w_is_div = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_accept = (r_state == IDLE) && start && (w_is_mul || w_is_div);
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state: leave IDLE on an accepted start and return after the last count
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = RUN;
            RUN:  if (r_cnt == CW'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // latch the op and operands at start so later srcA/srcB changes are invisible
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_cnt <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_op  <= mdOp;
            r_a   <= srcA;
            r_b   <= srcB;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Signed product: the low 64 bits of the product of sign-extended operands
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

`ifdef MD_UNIT_DIV_EN
    // The signed divide works on magnitudes. The quotient sign is the XOR of
    // the operand signs, and the remainder takes the dividend's sign.
    // 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
    logic [31:0] w_abs_a, w_abs_b, w_sq, w_sr, w_uq, w_ur;
    logic        w_div0;
    assign w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_div0  = (r_b == 32'd0);
    assign w_sq    = w_div0 ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_sr    = w_div0 ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_uq    = w_div0 ? 32'd0 : (r_a / r_b);
    assign w_ur    = w_div0 ? 32'd0 : (r_a % r_b);
`endif

    // select the HI/LO result of the latched op; divide by zero suppresses the write
    always_comb begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_we = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_we = 1'b1;
            end
`ifdef MD_UNIT_DIV_EN
            OP_DIV: begin
                w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_sq) : w_sq;
                w_res_hi = r_a[31] ? (32'd0 - w_sr) : w_sr;
                w_res_we = !w_div0;
            end
            OP_DIVU: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
                w_res_we = !w_div0;
            end
`endif
            default: w_res_we = 1'b0;
        endcase
    end

    // HI/LO: the result is written on the final RUN edge, and mthi/mtlo are honoured only in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            if (w_res_we) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (r_state == IDLE) begin
            if (mdOp == OP_MTHI) r_hi <= srcA;
            if (mdOp == OP_MTLO) r_lo <= srcA;
        end
    end

    assign busy     = (r_state == RUN);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mdResult = (mdOp == OP_MFHI) ? r_hi :
                      (mdOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, table-driven bench for md_unit. Expectations for
// div/divu follow whether MD_UNIT_DIV_EN is defined.
module tb_md_unit;

`ifdef MD_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  mdOp;
    logic [31:0] srcA, srcB;
    logic        busy;
    logic [31:0] mdResult, hi, lo;

    int total = 0;
    int bad   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
        .srcA(srcA), .srcB(srcB), .busy(busy), .mdResult(mdResult),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, ehi, elo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // count busy samples (taken 1 time unit after each edge) until busy drops
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge clk);
        start = 1'b1; mdOp = op; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0; mdOp = 4'd0; srcA = $urandom; srcB = $urandom;
        wait_busy(n);
    endtask

    initial begin
        int n, m, ecyc;
        logic [31:0] m_hi, m_lo;
        logic is_div;

        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[4] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003};
        vecs[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        reset = 1'b1; start = 1'b0; mdOp = 4'd0; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_mdresult", mdResult, 32'd0);
        mdOp = 4'd7; #1;
        chk("reset_mfhi", mdResult, 32'd0);
        mdOp = 4'd0;

        // mthi, then mfhi in the next cycle
        @(negedge clk); mdOp = 4'd5; srcA = 32'hABCD0000;
        @(posedge clk); #1;
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'hABCD0000);
        mdOp = 4'd7; srcA = '0; #1;
        chk("mfhi_result", mdResult, 32'hABCD0000);
        mdOp = 4'd8; #1;
        chk("mflo_result", mdResult, 32'd0);
        mdOp = 4'd0;

        m_hi = 32'hABCD0000; m_lo = 32'd0;
        for (int i = 0; i < 8; i++) begin
            is_div = (vecs[i].op == 4'd3) || (vecs[i].op == 4'd4);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            if (is_div && !DIV_EN) ecyc = 0;
            else begin
                ecyc = is_div ? 10 : 5;
                m_hi = vecs[i].ehi; m_lo = vecs[i].elo;
            end
            chk($sformatf("vec%0d_cycles", i), n, ecyc);
            chk($sformatf("vec%0d_hi", i), hi, m_hi);
            chk($sformatf("vec%0d_lo", i), lo, m_lo);
            mdOp = 4'd8; #1;
            chk($sformatf("vec%0d_mflo", i), mdResult, m_lo);
            mdOp = 4'd0;
        end

        // divu by zero leaves HI/LO alone but still takes the full latency
        @(negedge clk); mdOp = 4'd5; srcA = 32'h11;
        @(negedge clk); mdOp = 4'd6; srcA = 32'h22;
        @(negedge clk); mdOp = 4'd0;
        do_op(4'd4, 32'd5, 32'd0, n);
        chk("div0_cycles", n, DIV_EN ? 10 : 0);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        // mtlo and a second start arriving while busy must be ignored
        @(negedge clk); start = 1'b1; mdOp = 4'd1; srcA = 32'd3; srcB = 32'd4;
        @(posedge clk); #1;
        n = 0;
        if (busy) n++;
        @(negedge clk); start = 1'b0; mdOp = 4'd6; srcA = 32'hDEAD;
        @(posedge clk); #1;
        if (busy) n++;
        @(negedge clk); start = 1'b1; mdOp = 4'd1; srcA = 32'd100; srcB = 32'd100;
        @(posedge clk); #1;
        if (busy) n++;
        @(negedge clk); start = 1'b0; mdOp = 4'd0;
        @(posedge clk); #1;
        wait_busy(m);
        chk("busyrun_cycles", n + m, 32'd5);
        chk("busyrun_hi", hi, 32'd0);
        chk("busyrun_lo", lo, 32'd12);
        chk("busyrun_idle", {31'd0, busy}, 32'd0);

        // reset during the third busy cycle aborts the operation
        @(negedge clk); start = 1'b1; mdOp = 4'd1; srcA = 32'd5; srcB = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; mdOp = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b0;
        do_op(4'd1, 32'd5, 32'd6, n);
        chk("after_abort_cycles", n, 32'd5);
        chk("after_abort_hi", hi, 32'd0);
        chk("after_abort_lo", lo, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It sits beside the ALU and takes the same forwarded srcA/srcB operands. It owns the HI/LO registers and runs mult/multu/div/divu over several cycles. It also returns HI/LO for mfhi/mflo, and the E/M result mux selects that value instead of ALUResult.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears HI, LO, counter, busy
- start  in  1  E-stage instruction is mult/multu/div/divu; sampled at rising edge
- mdOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- srcA  in  32  rs operand (forwarded)
- srcB  in  32  rt operand (forwarded)
- busy  out  1  operation in progress
- mdResult  out  32  HI when mdOp=7, LO when mdOp=8, else 0 (combinational)
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on edge with start=1 and mdOp∈{1..4}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Latch the op and both operands internally.
- RUN:
  - Decrement the counter each edge.
  - When the counter reaches 1, the next edge writes HI/LO and returns to IDLE.
- Result rules:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Boundary results:
  - 0x80000000 / 0xFFFFFFFF (div) → LO=0x80000000, HI=0.
  - Divide by zero (div/divu): HI/LO unchanged, full DIV_CYCLES still elapse.
- mthi/mtlo (mdOp 5/6) in IDLE: HI or LO ← srcA at the edge, single cycle, busy stays 0.
- mfhi/mflo: mdResult is combinational from the current HI/LO, with no added latency.
- Commands ignored while busy:
  - start, mthi and mtlo are ignored; latched operands and the counter are unaffected.
  - The pipeline stall logic guarantees this case does not occur. The RTL still must not corrupt state if it does.
- Operand isolation: srcA/srcB changes after the start edge have no effect.

## Timing
- Reset values: busy=0, hi=0, lo=0, mdResult=0 (for mdOp≠7/8), state IDLE.
- Start accepted at edge E0:
  - busy=1 from after E0 through after E(N-1), with N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at EN; busy=0 after EN.
  - A back-to-back start is accepted at EN+1 at the earliest.
- Stall contract for the hazard unit: the D stage stalls when it holds a md-type instruction and (start | busy) = 1. This prevents an mfhi issued right behind a mult from reading stale HI/LO.
- Reset mid-operation: the operation is aborted at that edge; busy=0, HI=LO=0 after it.
- mthi/mtlo write at the same edge they are presented; a following mfhi in the next cycle sees the new value.

## Configuration
- MD_UNIT_DIV_EN defined:
  - div/divu are implemented as above.
- MD_UNIT_DIV_EN undefined:
  - The divider is not synthesized.
  - start with mdOp 3/4 is ignored: state stays IDLE, busy stays 0, HI/LO unchanged.
  - mult/multu/mthi/mtlo/mfhi/mflo are unaffected.

## Test plan
- Reset, then mult with srcA=0xFFFFFFFE (-2), srcB=3: busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div with srcA=0xFFFFFFF9 (-7), srcB=2: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 gives LO=3, HI=1; div 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu by zero with HI=0x11, LO=0x22 beforehand: busy lasts 10 cycles, HI/LO remain 0x11/0x22.
- mthi srcA=0xABCD0000 then mflo-free mfhi next cycle: mdResult=0xABCD0000, busy never asserted; mtlo during RUN has no effect.
- Start mult, then assert reset on the 3rd busy cycle: busy=0 and HI=LO=0 after that edge; a new mult started afterwards completes normally.
- Build without MD_UNIT_DIV_EN: div start keeps busy=0 and HI/LO unchanged; mult still yields correct results.
